// File: rtl/array_row_feeder_if.sv
// Interface bundling the command, L0-source and tile-drive signals of one array row feeder.
//   start/start_load/exec_len : command from the row controller
//   in_data/in_valid/in_ready : operand stream from the row's L0 buffer
//   out_w/inst_w              : drive into the leftmost mac_tile (in_w / inst_w)
//   busy/done/err/weights_loaded : status back to the controller
// master: the feeder side. slave: controller, L0 and tile side.
interface array_row_feeder_if #(
  parameter int unsigned bw     = 4,
  parameter int unsigned len_bw = 8
);
  logic              start;
  logic              start_load;
  logic [len_bw-1:0] exec_len;
  logic [bw-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [bw-1:0]     out_w;
  logic [1:0]        inst_w;
  logic              busy;
  logic              done;
  logic              err;
  logic              weights_loaded;

  modport master (
    input  start, start_load, exec_len, in_data, in_valid,
    output in_ready, out_w, inst_w, busy, done, err, weights_loaded
  );

  modport slave (
    output start, start_load, exec_len, in_data, in_valid,
    input  in_ready, out_w, inst_w, busy, done, err, weights_loaded
  );
endinterface

// File: rtl/array_row_feeder.sv
// West-edge driver for one systolic array row. Pulls operands from L0 over valid/ready and
// issues them to tile0: first col weights (inst_w=01), then gap idle cycles, then exec_len
// activations (inst_w=10). Outputs are registered (1-cycle latency from acceptance).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : array_row_feeder_if.master (command, L0 stream, tile drive, status)
module array_row_feeder #(
  parameter int unsigned bw     = 4,
  parameter int unsigned col    = 8,
  parameter int unsigned len_bw = 8,
  parameter int unsigned gap    = 2   // legal 0..15
) (
  input  logic               clk,
  input  logic               reset,
  array_row_feeder_if.master bus
);

  localparam int unsigned ColW = $clog2(col + 1);
  localparam int unsigned CntW = (len_bw > ColW) ? len_bw : ColW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_EXEC = 2'd3;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  logic [1:0]        r_state,   w_state_d;
  logic [CntW-1:0]   r_cnt,     w_cnt_d;
  logic [3:0]        r_gcnt,    w_gcnt_d;
  logic [len_bw-1:0] r_len,     w_len_d;
  logic [bw-1:0]     r_out_w,   w_out_w_d;
  logic [1:0]        r_inst_w,  w_inst_w_d;
  logic              r_done,    w_done_d;
  logic              r_err,     w_err_d;
  logic              r_wloaded, w_wloaded_d;

  logic w_in_ready;
  logic w_accept;

  // Ready depends only on state, never on in_valid, so L0 can't form a comb loop through us.
  assign w_in_ready = ((r_state == S_LOAD) || (r_state == S_EXEC)) && (r_cnt != '0);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_gcnt_d    = r_gcnt;
    w_len_d     = r_len;
    w_out_w_d   = r_out_w;   // out_w holds across bubbles
    w_inst_w_d  = INST_NOP;
    w_done_d    = 1'b0;
    w_err_d     = 1'b0;
    w_wloaded_d = r_wloaded;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_len_d = bus.exec_len;
          if (bus.start_load && !r_wloaded) begin
            w_state_d = S_LOAD;
            w_cnt_d   = CntW'(col);
          end else begin
            // Tiles can't re-capture weights without an array reset: flag and run execute-only.
            w_err_d = bus.start_load;
            if (bus.exec_len != '0) begin
              w_state_d = S_EXEC;
              w_cnt_d   = CntW'(bus.exec_len);
            end else begin
              w_done_d = 1'b1;
            end
          end
        end
      end

      S_LOAD: begin
        if (w_accept) begin
          w_out_w_d  = bus.in_data;
          w_inst_w_d = INST_LOAD;
          w_cnt_d    = r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) begin
            w_wloaded_d = 1'b1;
            if (gap != 0) begin
              w_state_d = S_GAP;
              w_gcnt_d  = 4'(gap);
            end else if (r_len != '0) begin
              w_state_d = S_EXEC;
              w_cnt_d   = CntW'(r_len);
            end else begin
              w_state_d = S_IDLE;
              w_done_d  = 1'b1;
            end
          end
        end
      end

      S_GAP: begin
        w_gcnt_d = r_gcnt - 4'd1;
        if (r_gcnt == 4'd1) begin
          if (r_len != '0) begin
            w_state_d = S_EXEC;
            w_cnt_d   = CntW'(r_len);
          end else begin
            w_state_d = S_IDLE;
            w_done_d  = 1'b1;
          end
        end
      end

      S_EXEC: begin
        if (w_accept) begin
          w_out_w_d  = bus.in_data;
          w_inst_w_d = INST_EXEC;
          w_cnt_d    = r_cnt - CntW'(1);
          // done registers on the same edge as the last beat, so both appear together.
          if (r_cnt == CntW'(1)) begin
            w_state_d = S_IDLE;
            w_done_d  = 1'b1;
          end
        end
      end

      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_gcnt    <= '0;
      r_len     <= '0;
      r_out_w   <= '0;
      r_inst_w  <= INST_NOP;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wloaded <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_gcnt    <= w_gcnt_d;
      r_len     <= w_len_d;
      r_out_w   <= w_out_w_d;
      r_inst_w  <= w_inst_w_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
      r_wloaded <= w_wloaded_d;
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_w          = r_out_w;
  assign bus.inst_w         = r_inst_w;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = r_done;
  assign bus.err            = r_err;
  assign bus.weights_loaded = r_wloaded;

endmodule

// File: doc/array_row_feeder.md
Name: array_row_feeder

Overview:
- West-edge driver for one row of the systolic MAC array: the transmitter side of the tile's in_w/inst_w interface.
- Pulls operands from the row's L0 buffer over valid/ready and issues them in two phases:
  - Kernel-load phase: COL weights, inst=2'b01.
  - Execute phase: exec_len activations, inst=2'b10.
- Drives the leftmost mac_tile's in_w and inst_w. Tiles latch weights in arrival order, so weight k lands in column k.

Parameters:
- bw, 4, operand width (matches tile bw)
- col, 8, tiles per row = weights per kernel load
- len_bw, 8, width of exec_len
- gap, 2, idle cycles (inst=00) inserted between last weight and first activation; legal range 0..15

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  command strobe, sampled only in IDLE
- start_load  input  1  with start: 1 = load kernel then execute, 0 = execute only
- exec_len  input  len_bw  activation count for this command, sampled with start
- in_data  input  bw  operand from L0
- in_valid  input  1  in_data valid
- in_ready  output  1  feeder accepts in_data this cycle
- out_w  output  bw  to tile0 in_w
- inst_w  output  2  to tile0 inst_w; [1] execute, [0] kernel load
- busy  output  1  high when not in IDLE
- done  output  1  one-cycle pulse, command complete
- err  output  1  one-cycle pulse, illegal reload request
- weights_loaded  output  1  sticky: kernel already loaded since reset

Behaviour:
- Reset (reset=0, async): state=IDLE; out_w=0, inst_w=00, in_ready=0, busy=0, done=0, err=0, weights_loaded=0; counters=0. Reset asserted mid-command aborts immediately; no partial completion is reported.
- FSM states: IDLE, LOAD, GAP, EXEC.
- IDLE + start:
  - start_load=1 and weights_loaded=0 -> LOAD, cnt=col.
  - start_load=1 and weights_loaded=1 -> err pulses next cycle; command treated as execute-only. Tiles cannot re-arm weight capture without an array reset.
  - Execute-only with exec_len>0 -> EXEC.
  - Execute-only with exec_len=0 -> done pulses next cycle; state stays IDLE.
- start outside IDLE is ignored, as are its exec_len and start_load.
- in_ready is combinational: 1 iff state is LOAD or EXEC and remaining count >0. It does not depend on in_valid.
- Beat accepted when in_valid & in_ready.
- Outputs are registered: an accepted beat appears on out_w/inst_w at the next edge, i.e. 1-cycle latency.
  - LOAD beat -> inst_w=01, out_w=in_data.
  - EXEC beat -> inst_w=10, out_w=in_data.
  - Any cycle without an accepted beat -> inst_w=00 and out_w holds its last value. Tiles treat 00 as a no-op, so L0 stalls are legal bubbles in either phase.
- LOAD: decrement cnt per accepted beat. On the edge of the col-th acceptance:
  - set weights_loaded=1;
  - go to GAP with gcnt=gap, or directly to EXEC/finish if gap=0.
- GAP: inst_w=00, in_ready=0 for exactly gap cycles. Then:
  - exec_len>0 -> EXEC with cnt=exec_len;
  - exec_len=0 -> done, IDLE.
- EXEC: decrement cnt per accepted beat. The last acceptance transitions to IDLE. done is registered so it is high in the same cycle the last beat is driven on inst_w=10.
- done and err are never high more than one cycle. With a reload request and exec_len=0, err and done pulse in the same cycle.
- busy = (state != IDLE).
- Total activations issued per command is exactly exec_len. Total weights issued over the whole run since reset is exactly col.

Test Plan:
- Reset checks: hold reset=0 mid-LOAD after 3 weights -> all outputs 0 asynchronously, weights_loaded=0; after release, a full load of 8 weights is accepted.
- Basic load + execute: start_load=1, exec_len=4, L0 always valid, weights 1..8, acts 9..12 -> inst_w=01 for 8 cycles with out_w=1..8, then 00 for 2 cycles, then 10 for 4 cycles with out_w=9..12; done pulses coincident with the 12 beat; weights_loaded=1.
- Stall: toggle in_valid 1,0,1,0 during both phases -> inst_w=00 in every stalled cycle, out_w holds, and the 8 weights and N acts still arrive in order.
- Reload: second command start_load=1, exec_len=3 -> err pulses once, no 01 beats issued, 3 beats with inst=10, done.
- Zero length:
  - exec-only with exec_len=0 -> done the cycle after start, busy stays 0.
  - load with exec_len=0 -> done after GAP ends, no 10 beats.
- Ignored start: pulse start during EXEC with different exec_len -> no effect on beat count or on done timing.
